// File: rtl/lt24_pkg.sv
// Shared definitions for the LT24 (ILI9341) pixel writer.
//   - ILI9341 command opcodes and init parameter bytes
//   - controller FSM state encoding
//   - init ROM entry layout and contents
package lt24_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_COLMOD  = 8'h3A;
    localparam logic [7:0] CMD_MADCTL  = 8'h36;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    localparam logic [7:0] PIXEL_FORMAT_565 = 8'h55;
    localparam logic [7:0] MADCTL_VALUE     = 8'h48;

    // ROM index of the sleep-out command; the long wait follows it
    localparam logic [2:0] INIT_SLPOUT_IDX = 3'd1;

    typedef enum logic [2:0] {
        RST_LOW,
        RST_WAIT,
        INIT_WORD,
        SLEEP_WAIT,
        IDLE,
        PIX_WORD
    } lt24_state_e;

    typedef struct packed {
        logic       last;     // end marker, no bus word
        logic       is_data;  // 1 = data word (RS=1)
        logic [7:0] value;
    } init_entry_t;

    function automatic init_entry_t init_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    return '{1'b0, 1'b0, CMD_SWRESET};
            3'd1:    return '{1'b0, 1'b0, CMD_SLPOUT};
            3'd2:    return '{1'b0, 1'b0, CMD_COLMOD};
            3'd3:    return '{1'b0, 1'b1, PIXEL_FORMAT_565};
            3'd4:    return '{1'b0, 1'b0, CMD_MADCTL};
            3'd5:    return '{1'b0, 1'b1, MADCTL_VALUE};
            3'd6:    return '{1'b0, 1'b0, CMD_DISPON};
            default: return '{1'b1, 1'b0, 8'h00};
        endcase
    endfunction

endpackage

// File: rtl/lt24_pixel_writer_if.sv
// Pixel write channel between the renderer and the LT24 writer.
//   xAddr/yAddr/pixelData/pixelWrite : request from the renderer
//   pixelReady                       : writer can accept a pixel this cycle
// master = renderer side, slave = writer side.
interface lt24_pixel_writer_if;
    logic [7:0]  xAddr;
    logic [8:0]  yAddr;
    logic [15:0] pixelData;
    logic        pixelWrite;
    logic        pixelReady;

    modport master (output xAddr, output yAddr, output pixelData,
                    output pixelWrite, input pixelReady);
    modport slave  (input xAddr, input yAddr, input pixelData,
                    input pixelWrite, output pixelReady);
endinterface

// File: rtl/lt24_bus_word.sv
// One 8080-style write cycle on the LT24 bus.
//   start/isData/word : launch a word (accepted when idle or in the done cycle)
//   wr_n/rs/data      : registered bus pins; rs/data held until the next start
//   done              : high in the last high-phase cycle, so a chained start
//                       begins the next low phase with no idle gap
module lt24_bus_word #(
    parameter int WR_LOW_CYCLES  = 2,
    parameter int WR_HIGH_CYCLES = 2
) (
    input  logic        clock,
    input  logic        resetApp,
    input  logic        start,
    input  logic        isData,
    input  logic [15:0] word,
    output logic        wr_n,
    output logic        rs,
    output logic [15:0] data,
    output logic        done
);
    localparam logic [15:0] LOW_LAST  = 16'(WR_LOW_CYCLES - 1);
    localparam logic [15:0] HIGH_LAST = 16'(WR_HIGH_CYCLES - 1);

    logic        busy_q, busy_d;
    logic        low_q, low_d;
    logic [15:0] cnt_q, cnt_d;
    logic        wr_n_q, wr_n_d;
    logic        rs_q, rs_d;
    logic [15:0] data_q, data_d;

    always_comb begin
        busy_d = busy_q;
        low_d  = low_q;
        cnt_d  = cnt_q;
        wr_n_d = wr_n_q;
        rs_d   = rs_q;
        data_d = data_q;
        done   = busy_q && !low_q && (cnt_q == HIGH_LAST);

        if (start && (!busy_q || done)) begin
            busy_d = 1'b1;
            low_d  = 1'b1;
            cnt_d  = '0;
            wr_n_d = 1'b0;
            rs_d   = isData;
            data_d = word;
        end else if (busy_q) begin
            if (low_q) begin
                if (cnt_q == LOW_LAST) begin
                    low_d  = 1'b0;
                    cnt_d  = '0;
                    wr_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end else if (done) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            busy_q <= 1'b0;
            low_q  <= 1'b0;
            cnt_q  <= '0;
            wr_n_q <= 1'b1;
            rs_q   <= 1'b1;
            data_q <= '0;
        end else begin
            busy_q <= busy_d;
            low_q  <= low_d;
            cnt_q  <= cnt_d;
            wr_n_q <= wr_n_d;
            rs_q   <= rs_d;
            data_q <= data_d;
        end
    end

    assign wr_n = wr_n_q;
    assign rs   = rs_q;
    assign data = data_q;
endmodule

// File: rtl/lt24_pixel_writer.sv
// LT24 pixel writer: runs the ILI9341 power-up sequence, then turns each
// accepted pixel into bus words. The column/page window is re-sent only when
// the pixel is not the raster successor of the previous one.
//   clock, resetApp     : clock and async active-high reset
//   pix (slave)         : renderer pixel channel with pixelReady backpressure
//   initDone            : init complete, sticky until reset
//   LT24*               : panel bus, reset and backlight pins
module lt24_pixel_writer
    import lt24_pkg::*;
#(
    parameter int LCD_WIDTH        = 240,
    parameter int LCD_HEIGHT       = 320,
    parameter int WR_LOW_CYCLES    = 2,
    parameter int WR_HIGH_CYCLES   = 2,
    parameter int RESET_LOW_CYCLES = 500000,
    parameter int INIT_WAIT_CYCLES = 6000000,
    parameter int DELAY_WIDTH      = 24
) (
    input  logic               clock,
    input  logic               resetApp,
    lt24_pixel_writer_if.slave pix,
    output logic               initDone,
    output logic               LT24Wr_n,
    output logic               LT24Rd_n,
    output logic               LT24CS_n,
    output logic               LT24RS,
    output logic               LT24Reset_n,
    output logic [15:0]        LT24Data,
    output logic               LT24LCDOn
);
    localparam logic [7:0] X_LAST = 8'(LCD_WIDTH - 1);
    localparam logic [8:0] Y_LAST = 9'(LCD_HEIGHT - 1);
    localparam logic [DELAY_WIDTH-1:0] RST_LAST  = DELAY_WIDTH'(RESET_LOW_CYCLES - 1);
    localparam logic [DELAY_WIDTH-1:0] WAIT_LAST = DELAY_WIDTH'(INIT_WAIT_CYCLES - 1);
    // Resync is words 0..11; the fast path starts directly at the pixel word
    localparam logic [3:0] PIX_DATA_IDX = 4'd11;

    lt24_state_e            state_q, state_d;
    logic [DELAY_WIDTH-1:0] delay_q, delay_d;
    logic [2:0]             rom_idx_q, rom_idx_d;
    logic [3:0]             pix_idx_q, pix_idx_d;
    logic [7:0]             x_q, x_d, ex_q, ex_d;
    logic [8:0]             y_q, y_d, ey_q, ey_d;
    logic [15:0]            pd_q, pd_d;
    logic                   win_valid_q, win_valid_d;
    logic                   init_done_q, init_done_d;
    logic                   cs_n_q, cs_n_d;
    logic                   reset_n_q, reset_n_d;
    logic                   lcd_on_q, lcd_on_d;

    logic        bus_start, bus_is_data, bus_done;
    logic [15:0] bus_word;
    logic        pixel_ready, in_range, fast, x_last;
    logic [3:0]  first_idx;
    init_entry_t rom_cur, rom_next;
    logic [16:0] pw_next;

    // {rs, word} of resync/pixel word idx
    function automatic logic [16:0] pix_word(input logic [3:0] idx, input logic [7:0] x,
                                             input logic [8:0] y, input logic [15:0] d);
        case (idx)
            4'd0:    return {1'b0, 8'h00, CMD_CASET};
            4'd1:    return {1'b1, 16'h0000};
            4'd2:    return {1'b1, 8'h00, x};
            4'd3:    return {1'b1, 16'h0000};
            4'd4:    return {1'b1, 8'h00, X_LAST};
            4'd5:    return {1'b0, 8'h00, CMD_PASET};
            4'd6:    return {1'b1, 15'h0000, y[8]};
            4'd7:    return {1'b1, 8'h00, y[7:0]};
            4'd8:    return {1'b1, 15'h0000, Y_LAST[8]};
            4'd9:    return {1'b1, 8'h00, Y_LAST[7:0]};
            4'd10:   return {1'b0, 8'h00, CMD_RAMWR};
            default: return {1'b1, d};
        endcase
    endfunction

    assign pixel_ready = (state_q == IDLE) && init_done_q;
    assign in_range    = (int'(pix.xAddr) < LCD_WIDTH) && (int'(pix.yAddr) < LCD_HEIGHT);
    assign fast        = win_valid_q && (pix.xAddr == ex_q) && (pix.yAddr == ey_q);
    assign x_last      = (pix.xAddr == X_LAST);
    assign first_idx   = fast ? PIX_DATA_IDX : 4'd0;
    assign rom_cur     = init_rom(rom_idx_q);
    assign rom_next    = init_rom(rom_idx_q + 3'd1);
    assign pw_next     = pix_word(pix_idx_q + 4'd1, x_q, y_q, pd_q);

    always_comb begin
        state_d     = state_q;
        delay_d     = delay_q;
        rom_idx_d   = rom_idx_q;
        pix_idx_d   = pix_idx_q;
        x_d         = x_q;
        y_d         = y_q;
        pd_d        = pd_q;
        ex_d        = ex_q;
        ey_d        = ey_q;
        win_valid_d = win_valid_q;
        init_done_d = init_done_q;
        cs_n_d      = cs_n_q;
        reset_n_d   = reset_n_q;
        lcd_on_d    = lcd_on_q;
        bus_start   = 1'b0;
        bus_is_data = 1'b0;
        bus_word    = '0;

        case (state_q)
            RST_LOW: begin
                if (delay_q == RST_LAST) begin
                    delay_d   = '0;
                    reset_n_d = 1'b1;
                    lcd_on_d  = 1'b1;
                    state_d   = RST_WAIT;
                end else begin
                    delay_d = delay_q + 1'b1;
                end
            end
            RST_WAIT, SLEEP_WAIT: begin
                // Both waits end by launching the ROM word at rom_idx_q
                if (delay_q == WAIT_LAST) begin
                    delay_d     = '0;
                    bus_start   = 1'b1;
                    bus_is_data = rom_cur.is_data;
                    bus_word    = {8'h00, rom_cur.value};
                    cs_n_d      = 1'b0;
                    state_d     = INIT_WORD;
                end else begin
                    delay_d = delay_q + 1'b1;
                end
            end
            INIT_WORD: begin
                if (bus_done) begin
                    rom_idx_d = rom_idx_q + 3'd1;
                    if (rom_idx_q == INIT_SLPOUT_IDX) begin
                        state_d = SLEEP_WAIT;
                    end else if (rom_next.last) begin
                        init_done_d = 1'b1;
                        cs_n_d      = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        bus_start   = 1'b1;
                        bus_is_data = rom_next.is_data;
                        bus_word    = {8'h00, rom_next.value};
                    end
                end
            end
            IDLE: begin
                if (pix.pixelWrite && pixel_ready) begin
                    x_d  = pix.xAddr;
                    y_d  = pix.yAddr;
                    pd_d = pix.pixelData;
                    ex_d = x_last ? 8'd0 : pix.xAddr + 8'd1;
                    ey_d = !x_last ? pix.yAddr :
                           (pix.yAddr == Y_LAST) ? 9'd0 : pix.yAddr + 9'd1;
                    if (!in_range) begin
                        win_valid_d = 1'b0;
                    end else begin
                        // First word launches on the accept edge from the live inputs
                        pix_idx_d = first_idx;
                        {bus_is_data, bus_word} =
                            pix_word(first_idx, pix.xAddr, pix.yAddr, pix.pixelData);
                        bus_start = 1'b1;
                        cs_n_d    = 1'b0;
                        state_d   = PIX_WORD;
                    end
                end
            end
            PIX_WORD: begin
                if (bus_done) begin
                    if (pix_idx_q == PIX_DATA_IDX) begin
                        win_valid_d = 1'b1;
                        cs_n_d      = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        pix_idx_d   = pix_idx_q + 4'd1;
                        bus_start   = 1'b1;
                        bus_is_data = pw_next[16];
                        bus_word    = pw_next[15:0];
                    end
                end
            end
            default: state_d = RST_LOW;
        endcase
    end

    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            state_q     <= RST_LOW;
            delay_q     <= '0;
            rom_idx_q   <= '0;
            pix_idx_q   <= '0;
            x_q         <= '0;
            y_q         <= '0;
            pd_q        <= '0;
            ex_q        <= '0;
            ey_q        <= '0;
            win_valid_q <= 1'b0;
            init_done_q <= 1'b0;
            cs_n_q      <= 1'b1;
            reset_n_q   <= 1'b0;
            lcd_on_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            delay_q     <= delay_d;
            rom_idx_q   <= rom_idx_d;
            pix_idx_q   <= pix_idx_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pd_q        <= pd_d;
            ex_q        <= ex_d;
            ey_q        <= ey_d;
            win_valid_q <= win_valid_d;
            init_done_q <= init_done_d;
            cs_n_q      <= cs_n_d;
            reset_n_q   <= reset_n_d;
            lcd_on_q    <= lcd_on_d;
        end
    end

    lt24_bus_word #(
        .WR_LOW_CYCLES (WR_LOW_CYCLES),
        .WR_HIGH_CYCLES(WR_HIGH_CYCLES)
    ) u_bus_word (
        .clock   (clock),
        .resetApp(resetApp),
        .start   (bus_start),
        .isData  (bus_is_data),
        .word    (bus_word),
        .wr_n    (LT24Wr_n),
        .rs      (LT24RS),
        .data    (LT24Data),
        .done    (bus_done)
    );

    assign pix.pixelReady = pixel_ready;
    assign initDone       = init_done_q;
    assign LT24Rd_n       = 1'b1;
    assign LT24CS_n       = cs_n_q;
    assign LT24Reset_n    = reset_n_q;
    assign LT24LCDOn      = lcd_on_q;
endmodule

// File: tb/tb_lt24_pixel_writer.sv
module tb_lt24_pixel_writer;
    localparam int W  = 240;
    localparam int H  = 320;
    localparam int WL = 2;
    localparam int WH = 2;

    logic clock = 1'b0;
    logic resetApp = 1'b1;
    always #5 clock = ~clock;

    lt24_pixel_writer_if pif();
    logic        initDone, LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS, LT24Reset_n, LT24LCDOn;
    logic [15:0] LT24Data;

    lt24_pixel_writer #(
        .LCD_WIDTH(W), .LCD_HEIGHT(H), .WR_LOW_CYCLES(WL), .WR_HIGH_CYCLES(WH),
        .RESET_LOW_CYCLES(4), .INIT_WAIT_CYCLES(10), .DELAY_WIDTH(24)
    ) dut (
        .clock(clock), .resetApp(resetApp), .pix(pif), .initDone(initDone),
        .LT24Wr_n(LT24Wr_n), .LT24Rd_n(LT24Rd_n), .LT24CS_n(LT24CS_n), .LT24RS(LT24RS),
        .LT24Reset_n(LT24Reset_n), .LT24Data(LT24Data), .LT24LCDOn(LT24LCDOn)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- bus monitor ----------------
    typedef struct {
        logic        rs;
        logic [15:0] data;
        int          low;
        longint      start;
    } word_t;

    word_t  mon_q[$];
    word_t  cur;
    int     mon_starts = 0;
    int     glitch = 0;
    longint cyc = 0;
    logic   prev_wr = 1'b1;
    logic   in_low = 1'b0;
    logic   hi_track = 1'b0;
    int     hi_cnt = 0;

    always @(negedge clock) begin
        cyc++;
        if (resetApp) begin
            prev_wr  = 1'b1;
            in_low   = 1'b0;
            hi_track = 1'b0;
        end else begin
            if (prev_wr && !LT24Wr_n) begin
                cur.rs = LT24RS; cur.data = LT24Data; cur.low = 1; cur.start = cyc;
                in_low = 1'b1; hi_track = 1'b0; mon_starts++;
                if (LT24CS_n !== 1'b0) glitch++;
            end else if (!LT24Wr_n) begin
                cur.low++;
                if (LT24RS !== cur.rs || LT24Data !== cur.data || LT24CS_n !== 1'b0) glitch++;
            end else if (in_low) begin
                in_low = 1'b0; mon_q.push_back(cur); hi_track = 1'b1; hi_cnt = 1;
                if (LT24RS !== cur.rs || LT24Data !== cur.data || LT24CS_n !== 1'b0) glitch++;
            end else if (hi_track) begin
                if (hi_cnt < WH) begin
                    hi_cnt++;
                    if (LT24RS !== cur.rs || LT24Data !== cur.data) glitch++;
                end else begin
                    hi_track = 1'b0;
                end
            end
            prev_wr = LT24Wr_n;
        end
    end

    // ---------------- reference model ----------------
    logic [16:0] exp_q[$];
    bit m_valid = 1'b0;
    int m_ex = 0, m_ey = 0;

    function automatic void push_w(input bit rs, input int v);
        exp_q.push_back({rs, 16'(v)});
    endfunction

    // Expected words for one accepted pixel; returns the word count
    function automatic int model_accept(input int x, input int y, input logic [15:0] d);
        int lin;
        int n;
        if (x >= W || y >= H) begin
            m_valid = 1'b0;
            return 0;
        end
        if (m_valid && x == m_ex && y == m_ey) begin
            exp_q.push_back({1'b1, d});
            n = 1;
        end else begin
            push_w(0, 'h2A); push_w(1, 0); push_w(1, x); push_w(1, 0); push_w(1, W - 1);
            push_w(0, 'h2B); push_w(1, y / 256); push_w(1, y % 256);
            push_w(1, (H - 1) / 256); push_w(1, (H - 1) % 256);
            push_w(0, 'h2C);
            exp_q.push_back({1'b1, d});
            n = 12;
            m_valid = 1'b1;
        end
        lin  = (y * W + x + 1) % (W * H);
        m_ex = lin % W;
        m_ey = lin / W;
        return n;
    endfunction

    task automatic compare_words(input string tag);
        int n;
        check({tag, "_word_count"}, mon_q.size(), exp_q.size());
        n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_word%0d", tag, i), 32'({mon_q[i].rs, mon_q[i].data}), 32'(exp_q[i]));
            check($sformatf("%s_wrlow%0d", tag, i), mon_q[i].low, WL);
        end
        mon_q.delete();
        exp_q.delete();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic accept_only(input int x, input int y, input logic [15:0] d);
        int t = 0;
        while (pif.pixelReady !== 1'b1 && t < 300) begin
            @(negedge clock);
            t++;
        end
        check("ready_wait_timeout", (t < 300), 1);
        pif.xAddr = 8'(x); pif.yAddr = 9'(y); pif.pixelData = d; pif.pixelWrite = 1'b1;
        @(negedge clock);
        pif.pixelWrite = 1'b0;
    endtask

    task automatic send_pixel(input string tag, input int x, input int y, input logic [15:0] d);
        int busy = 0;
        int nw;
        accept_only(x, y, d);
        nw = model_accept(x, y, d);
        while (pif.pixelReady !== 1'b1 && busy < 1000) begin
            busy++;
            @(negedge clock);
        end
        check({tag, "_busy"}, busy, nw * (WL + WH));
        compare_words(tag);
    endtask

    task automatic do_init(input string tag);
        int n = 0;
        int t = 0;
        int gap;
        repeat (3) @(negedge clock);
        check({tag, "_rst_wr_n"}, LT24Wr_n, 1);
        check({tag, "_rst_rd_n"}, LT24Rd_n, 1);
        check({tag, "_rst_cs_n"}, LT24CS_n, 1);
        check({tag, "_rst_rs"}, LT24RS, 1);
        check({tag, "_rst_reset_n"}, LT24Reset_n, 0);
        check({tag, "_rst_data"}, LT24Data, 0);
        check({tag, "_rst_lcdon"}, LT24LCDOn, 0);
        check({tag, "_rst_ready"}, pif.pixelReady, 0);
        check({tag, "_rst_initdone"}, initDone, 0);
        mon_q.delete();
        exp_q.delete();
        m_valid = 1'b0;
        resetApp = 1'b0;
        while (n < 100) begin
            @(posedge clock);
            n++;
            #1;
            if (LT24Reset_n === 1'b1) break;
        end
        check({tag, "_reset_low_clocks"}, n, 4);
        check({tag, "_lcdon"}, LT24LCDOn, 1);
        while (initDone !== 1'b1 && t < 500) begin
            @(negedge clock);
            t++;
        end
        @(negedge clock);
        check({tag, "_initdone"}, initDone, 1);
        check({tag, "_ready_after_init"}, pif.pixelReady, 1);
        check({tag, "_cs_after_init"}, LT24CS_n, 1);
        gap = (mon_q.size() >= 3) ? int'(mon_q[2].start - mon_q[1].start) - (WL + WH) : -1;
        check({tag, "_sleep_gap_ge10"}, (gap >= 10), 1);
        push_w(0, 'h01); push_w(0, 'h11); push_w(0, 'h3A); push_w(1, 'h55);
        push_w(0, 'h36); push_w(1, 'h48); push_w(0, 'h29);
        compare_words({tag, "_rom"});
    endtask

    initial begin
        int x, y, r, t, base;
        logic [15:0] d;
        pif.xAddr = '0; pif.yAddr = '0; pif.pixelData = '0; pif.pixelWrite = 1'b0;
        resetApp = 1'b1;
        @(negedge clock);

        do_init("init1");

        send_pixel("first", 0, 0, 16'hF800);
        send_pixel("succ", 1, 0, 16'h07E0);
        send_pixel("row_end", 239, 0, 16'h1234);
        send_pixel("row_wrap", 0, 1, 16'h4321);
        send_pixel("last_px", 239, 319, 16'hAAAA);
        send_pixel("frame_wrap", 0, 0, 16'h5555);
        send_pixel("jump_a", 5, 0, 16'h0F0F);
        send_pixel("jump_b", 100, 200, 16'hF0F0);
        send_pixel("oor_x", 250, 3, 16'hDEAD);
        send_pixel("after_oor", 0, 4, 16'hBEEF);
        send_pixel("oor_y", 1, 400, 16'hCAFE);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6 && m_valid) begin
                x = m_ex; y = m_ey;
            end else if (r < 8) begin
                x = $urandom_range(0, W - 1); y = $urandom_range(0, H - 1);
            end else if (r == 8) begin
                x = W - 1; y = ($urandom_range(0, 1) == 1) ? H - 1 : $urandom_range(0, H - 1);
            end else if ($urandom_range(0, 1) == 1) begin
                x = $urandom_range(W, 255); y = $urandom_range(0, H - 1);
            end else begin
                x = $urandom_range(0, W - 1); y = $urandom_range(H, 511);
            end
            d = 16'($urandom);
            send_pixel($sformatf("rnd%0d", i), x, y, d);
        end

        // Reset during the low phase of the 7th word of a resync
        base = mon_starts;
        accept_only(10, 10, 16'h1357);
        t = 0;
        while (t < 200) begin
            @(negedge clock);
            #2;
            t++;
            if (mon_starts == base + 7 && LT24Wr_n === 1'b0) break;
        end
        check("abort_reached_word7", (t < 200), 1);
        resetApp = 1'b1;
        #1;
        check("abort_wr_n", LT24Wr_n, 1);
        check("abort_cs_n", LT24CS_n, 1);
        check("abort_reset_n", LT24Reset_n, 0);
        check("abort_lcdon", LT24LCDOn, 0);
        @(negedge clock);

        do_init("init2");
        send_pixel("post_reset_resync", 11, 10, 16'h2468);
        send_pixel("post_reset_succ", 12, 10, 16'h8642);

        check("bus_word_stability", glitch, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
